// File: rtl/fball_pkg.sv
// Shared fireball constants and state encoding, also used by the sprite ROM and colour mapper.
package fball_pkg;
   localparam int SPRITE_W = 21;
   localparam int SPRITE_H = 21;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int COORD_W  = 10;
   localparam int ADDR_W   = 9;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      FLY      = 2'd2,
      COOLDOWN = 2'd3
   } fball_state_e;
endpackage

// File: rtl/fball_if.sv
// Launch/frame/beam inputs and sprite address/status outputs of the fireball controller.
interface fball_if;
   import fball_pkg::*;

   logic                frame_tick;
   logic                fire;
   logic [COORD_W-1:0]  spawn_x;
   logic [COORD_W-1:0]  spawn_y;
   logic [COORD_W-1:0]  draw_x;
   logic [COORD_W-1:0]  draw_y;
   logic [ADDR_W-1:0]   read_address;
   logic                fball_on;
   logic                active;
   logic                ready;

   modport master (
      output frame_tick, fire, spawn_x, spawn_y, draw_x, draw_y,
      input  read_address, fball_on, active, ready
   );

   modport slave (
      input  frame_tick, fire, spawn_x, spawn_y, draw_x, draw_y,
      output read_address, fball_on, active, ready
   );
endinterface

// File: rtl/fball_addr_gen.sv
// Combinational sprite box test and row-major ROM address (dy*W + dx) for the current beam pixel.
module fball_addr_gen
   import fball_pkg::*;
#(
   parameter int W = SPRITE_W,
   parameter int H = SPRITE_H
) (
   input  logic [COORD_W-1:0] draw_x,
   input  logic [COORD_W-1:0] draw_y,
   input  logic [COORD_W-1:0] ball_x,
   input  logic [COORD_W-1:0] ball_y,
   input  logic               fly,
   output logic               inbox,
   output logic [ADDR_W-1:0]  addr
);
   logic [COORD_W-1:0] dx;
   logic [COORD_W-1:0] dy;

   // Beam left of / above the sprite wraps to a large unsigned offset and fails the compare.
   always_comb begin
      dx    = draw_x - ball_x;
      dy    = draw_y - ball_y;
      inbox = fly && (dx < COORD_W'(W)) && (dy < COORD_W'(H));
      addr  = '0;
      if (inbox)
         addr = dy[ADDR_W-1:0] * ADDR_W'(W) + dx[ADDR_W-1:0];
   end
endmodule

// File: rtl/fball_ctrl.sv
// Fireball launch/flight/cooldown sequencer with registered sprite ROM address output.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | ready for launch; fire latches spawn position
// ARMED    | waiting for next frame_tick to place ball at spawn
// FLY      | ball rises SPEED px per frame; drawn via address path
// COOLDOWN | down-counting frames before another launch is allowed
module fball_ctrl #(
   parameter int SPRITE_W        = fball_pkg::SPRITE_W,
   parameter int SPRITE_H        = fball_pkg::SPRITE_H,
   parameter int SPEED           = 4,
   parameter int RANGE           = 160,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic    clk,
   input  logic    reset_n,
   fball_if.slave  bus
);
   import fball_pkg::*;

   fball_state_e       state, state_next;
   logic [COORD_W-1:0] spawn_x_q, spawn_y_q;
   logic [COORD_W-1:0] ball_x, ball_y;
   logic [COORD_W-1:0] travel;
   logic [7:0]         cnt;
   logic               retire;
   logic               inbox;
   logic [ADDR_W-1:0]  addr;

   assign retire = (ball_y < COORD_W'(SPEED)) ||
                   (({1'b0, travel} + (COORD_W+1)'(SPEED)) > (COORD_W+1)'(RANGE));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (bus.fire)       state_next = ARMED;
         ARMED:    if (bus.frame_tick) state_next = FLY;
         FLY:      if (bus.frame_tick && retire)
                      state_next = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
         COOLDOWN: if (bus.frame_tick && (cnt <= 8'd1)) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.ready  = (state == IDLE);
      bus.active = (state == FLY);
   end

   // Motion state only moves on frame_tick, which lands in vertical blank.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spawn_x_q <= '0;
         spawn_y_q <= '0;
         ball_x    <= '0;
         ball_y    <= '0;
         travel    <= '0;
         cnt       <= '0;
      end else begin
         if (state == IDLE && bus.fire) begin
            spawn_x_q <= bus.spawn_x;
            spawn_y_q <= bus.spawn_y;
         end
         if (bus.frame_tick) begin
            case (state)
               ARMED: begin
                  ball_x <= spawn_x_q;
                  ball_y <= spawn_y_q;
                  travel <= '0;
               end
               FLY: begin
                  if (retire) begin
                     cnt <= 8'(COOLDOWN_FRAMES);
                  end else begin
                     ball_y <= ball_y - COORD_W'(SPEED);
                     travel <= travel + COORD_W'(SPEED);
                  end
               end
               COOLDOWN: if (cnt > 8'd1) cnt <= cnt - 8'd1;
               default: ;
            endcase
         end
      end
   end

   fball_addr_gen #(.W(SPRITE_W), .H(SPRITE_H)) u_addr_gen (
      .draw_x (bus.draw_x),
      .draw_y (bus.draw_y),
      .ball_x (ball_x),
      .ball_y (ball_y),
      .fly    (state == FLY),
      .inbox  (inbox),
      .addr   (addr)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.read_address <= '0;
         bus.fball_on     <= 1'b0;
      end else begin
         bus.read_address <= addr;
         bus.fball_on     <= inbox;
      end
   end
endmodule

// File: tb/tb_fball_ctrl.sv
// Directed bench for fball_ctrl: expected outputs queued at stimulus time, popped after the DUT responds.
module tb_fball_ctrl;
   logic clk;
   logic reset_n;

   fball_if bus ();

   fball_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int K_ADDR   = 0;
   localparam int K_ON     = 1;
   localparam int K_ACTIVE = 2;
   localparam int K_READY  = 3;

   typedef struct {
      string      tag;
      int         kind;
      logic [9:0] exp;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   task automatic push(input string tag, input int kind, input logic [9:0] exp);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t       e;
      logic [9:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            K_ADDR:   obs = {1'b0, bus.read_address};
            K_ON:     obs = {9'd0, bus.fball_on};
            K_ACTIVE: obs = {9'd0, bus.active};
            default:  obs = {9'd0, bus.ready};
         endcase
         total++;
         assert (obs === e.exp) passed++;
         else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
   endtask

   task automatic fire_at(input logic [9:0] x, input logic [9:0] y);
      bus.fire    = 1'b1;
      bus.spawn_x = x;
      bus.spawn_y = y;
      step();
      bus.fire    = 1'b0;
   endtask

   task automatic status(input string tag, input logic act, input logic rdy);
      push({tag, ".active"}, K_ACTIVE, {9'd0, act});
      push({tag, ".ready"},  K_READY,  {9'd0, rdy});
      check_all();
   endtask

   task automatic draw(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic on, input logic [9:0] addr);
      bus.draw_x = x;
      bus.draw_y = y;
      push({tag, ".fball_on"}, K_ON, {9'd0, on});
      push({tag, ".read_address"}, K_ADDR, addr);
      step();
      check_all();
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.frame_tick = 1'b0;
      bus.fire       = 1'b0;
      bus.spawn_x    = '0;
      bus.spawn_y    = '0;
      bus.draw_x     = '0;
      bus.draw_y     = '0;
      step();
      step();
      push("rst.read_address", K_ADDR, 10'd0);
      push("rst.fball_on", K_ON, 10'd0);
      status("rst", 1'b0, 1'b1);
      reset_n = 1'b1;
      step();

      // Launch at (100,300) and probe sprite corners.
      fire_at(10'd100, 10'd300);
      status("armed", 1'b0, 1'b0);
      tick();
      status("fly", 1'b1, 1'b0);
      draw("tl",     10'd100, 10'd300, 1'b1, 10'd0);
      draw("br",     10'd120, 10'd320, 1'b1, 10'd440);
      draw("right",  10'd121, 10'd300, 1'b0, 10'd0);
      draw("below",  10'd100, 10'd321, 1'b0, 10'd0);
      draw("mid",    10'd110, 10'd305, 1'b1, 10'd115);
      draw("left",   10'd99,  10'd305, 1'b0, 10'd0);

      fire_at(10'd5, 10'd5);
      status("fire_in_fly", 1'b1, 1'b0);
      draw("fly_no_respawn", 10'd100, 10'd300, 1'b1, 10'd0);

      // 40 moves bring ball_y to 140 with travel exactly 160.
      for (int i = 0; i < 40; i++) tick();
      status("after40", 1'b1, 1'b0);
      draw("y140",   10'd100, 10'd140, 1'b1, 10'd0);
      draw("y139",   10'd100, 10'd139, 1'b0, 10'd0);
      draw("y160",   10'd104, 10'd160, 1'b1, 10'd424);
      tick();
      status("retire_range", 1'b0, 1'b0);
      draw("cool_off", 10'd100, 10'd140, 1'b0, 10'd0);
      fire_at(10'd7, 10'd7);
      status("fire_in_cool", 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) tick();
      status("cool7", 1'b0, 1'b0);
      tick();
      status("cool8", 1'b0, 1'b1);
      step();
      status("no_queued_fire", 1'b0, 1'b1);

      // Simultaneous fire + frame_tick, then top-of-screen retirement.
      bus.fire       = 1'b1;
      bus.frame_tick = 1'b1;
      bus.spawn_x    = 10'd50;
      bus.spawn_y    = 10'd6;
      step();
      bus.fire       = 1'b0;
      bus.frame_tick = 1'b0;
      status("fire_tick", 1'b0, 1'b0);
      tick();
      status("top_fly", 1'b1, 1'b0);
      draw("top_y6", 10'd50, 10'd6, 1'b1, 10'd0);
      tick();
      draw("top_y2", 10'd50, 10'd2, 1'b1, 10'd0);
      draw("top_dy4", 10'd50, 10'd6, 1'b1, 10'd84);
      tick();
      status("retire_top", 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) tick();
      status("top_idle", 1'b0, 1'b1);

      // Ball at origin: beam to the left wraps dx and must stay off.
      fire_at(10'd0, 10'd0);
      tick();
      status("origin_fly", 1'b1, 1'b0);
      draw("neg_dx", 10'd639, 10'd5,  1'b0, 10'd0);
      draw("neg_dy", 10'd5,   10'd479, 1'b0, 10'd0);
      draw("origin_br", 10'd20, 10'd20, 1'b1, 10'd440);
      tick();
      status("origin_retire", 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) tick();
      status("origin_idle", 1'b0, 1'b1);

      // Asynchronous reset in mid-flight.
      fire_at(10'd200, 10'd60);
      tick();
      draw("pre_rst", 10'd200, 10'd60, 1'b1, 10'd0);
      reset_n = 1'b0;
      #1;
      push("midrst.read_address", K_ADDR, 10'd0);
      push("midrst.fball_on", K_ON, 10'd0);
      status("midrst", 1'b0, 1'b1);
      step();
      reset_n = 1'b1;
      step();
      status("post_rst", 1'b0, 1'b1);
      draw("post_rst_draw", 10'd200, 10'd60, 1'b0, 10'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
